// File: rtl/timer_pkg.sv
// Purpose: shared constants, state type and digit-clamp helper for the BCD countdown timer.
// Latency: none; this file holds declarations only.
// Backpressure: not applicable.
package timer_pkg;

  // State encoding, shared with anything that decodes the timer state
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Per-digit moduli: decimal digits wrap at 9, seconds tens wraps at 5
  localparam logic [3:0] DIG_MAX9 = 4'd9;
  localparam logic [3:0] DIG_MAX5 = 4'd5;

  // Whole-display constants in {m10,m1,s10,s1} order
  localparam logic [15:0] ZERO_T = 16'h0000;
  // The only value whose single-second decrement lands on 00:00
  localparam logic [15:0] LAST_T = 16'h0001;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_PAUSE = S_PAUSE,
    ST_DONE  = S_DONE
  } state_e;

  // Clamp a preloaded digit to its modulus so illegal BCD never enters the chain
  function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// Purpose: one BCD down-counting digit with clamped load and borrow ripple to the next digit.
// Latency: q updates on the edge after ld or bi; bo is combinational from bi and q.
// Backpressure: none; a decrement request (bi) is always accepted.
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic       c,
  input  logic       r,
  input  logic       ld,
  input  logic [3:0] d,
  input  logic       bi,
  input  logic [3:0] max,
  output logic [3:0] q,
  output logic       bo
);

  // Borrow propagates only when this digit is asked to step down from zero
  assign bo = bi & (q == 4'd0);

  // Digit register: reset > clamped load > decrement with wrap to the modulus
  always_ff @(posedge c) begin
    if (r) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= clamp_digit(d, max);
    end else if (bi) begin
      q <= (q == 4'd0) ? max : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Purpose: MM:SS BCD countdown timer with IDLE/RUN/PAUSE/DONE control and a completion pulse.
// Latency: ld and go take effect on the next edge; a tick in RUN updates t on the same edge.
// Backpressure: none; ticks outside RUN are dropped, control inputs resolve by r > ld > hold > go > e.
module bcd_countdown_timer
  import timer_pkg::*;
(
  input  logic        c,
  input  logic        r,
  input  logic        e,
  input  logic        ld,
  input  logic [15:0] d,
  input  logic        go,
  input  logic        hold,
  output logic [15:0] t,
  output logic        run,
  output logic        done,
  output logic        zp
);

  state_e state_q;
  state_e state_nxt;
  logic   zp_nxt;

  logic [3:0] s1_q;
  logic [3:0] s10_q;
  logic [3:0] m1_q;
  logic [3:0] m10_q;

  logic dec;
  logic b_s1;
  logic b_s10;
  logic b_m1;
  logic bo_m10;
  logic unused_borrow;

  // Only a tick in RUN that is not overridden by hold starts the borrow chain;
  // ld and r take priority inside each digit.
  assign dec = e & (state_q == ST_RUN) & ~hold;

  // Reaching 00:00 from RUN always exits RUN, so m10 can never actually borrow
  assign unused_borrow = bo_m10;

  bcd_down_digit u_s1 (
    .c(c), .r(r), .ld(ld), .d(d[3:0]), .bi(dec), .max(DIG_MAX9),
    .q(s1_q), .bo(b_s1)
  );

  bcd_down_digit u_s10 (
    .c(c), .r(r), .ld(ld), .d(d[7:4]), .bi(b_s1), .max(DIG_MAX5),
    .q(s10_q), .bo(b_s10)
  );

  bcd_down_digit u_m1 (
    .c(c), .r(r), .ld(ld), .d(d[11:8]), .bi(b_s10), .max(DIG_MAX9),
    .q(m1_q), .bo(b_m1)
  );

  bcd_down_digit u_m10 (
    .c(c), .r(r), .ld(ld), .d(d[15:12]), .bi(b_m1), .max(DIG_MAX9),
    .q(m10_q), .bo(bo_m10)
  );

  assign t = {m10_q, m1_q, s10_q, s1_q};

  // Next-state and completion-pulse decode; zero is detected on the current
  // value so done and zp land on the same edge as t reaching 0000
  always_comb begin
    state_nxt = state_q;
    zp_nxt    = 1'b0;
    if (ld) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            if (t == ZERO_T) begin
              state_nxt = ST_DONE;
              zp_nxt    = 1'b1;
            end else begin
              state_nxt = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (hold) begin
            state_nxt = ST_PAUSE;
          end else if (e && (t == LAST_T)) begin
            state_nxt = ST_DONE;
            zp_nxt    = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (go) begin
            state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          state_nxt = ST_DONE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and status flags are registered so run/done/zp have no input-to-output path
  always_ff @(posedge c) begin
    if (r) begin
      state_q <= ST_IDLE;
      run     <= 1'b0;
      done    <= 1'b0;
      zp      <= 1'b0;
    end else begin
      state_q <= state_nxt;
      run     <= (state_nxt == ST_RUN);
      done    <= (state_nxt == ST_DONE);
      zp      <= zp_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Purpose: randomized and directed stimulus for bcd_countdown_timer against a seconds-based model.
// Latency: one expected entry per clock edge, checked 1 time unit after that edge.
// Backpressure: not applicable; the driver never stalls.
module tb_bcd_countdown_timer;

  logic        c = 1'b0;
  logic        r = 1'b1;
  logic        e = 1'b0;
  logic        ld = 1'b0;
  logic [15:0] d = 16'h0000;
  logic        go = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] t;
  logic        run;
  logic        done;
  logic        zp;

  always #5 c = ~c;

  bcd_countdown_timer dut (
    .c(c), .r(r), .e(e), .ld(ld), .d(d), .go(go), .hold(hold),
    .t(t), .run(run), .done(done), .zp(zp)
  );

  typedef struct {
    logic [15:0] t;
    logic        run;
    logic        done;
    logic        zp;
    string       tag;
  } exp_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string cur_tag = "reset";

  // Model state: remaining time in whole seconds and a mode number
  // (0 idle, 1 run, 2 pause, 3 done)
  int secs = 0;
  int mode = 0;

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int dig(input logic [3:0] v, input int mx);
    int x;
    x = int'(v);
    return (x > mx) ? mx : x;
  endfunction

  function automatic int load_secs(input logic [15:0] v);
    return (dig(v[15:12], 9) * 10 + dig(v[11:8], 9)) * 60
           + dig(v[7:4], 5) * 10 + dig(v[3:0], 9);
  endfunction

  // Apply one cycle of inputs, advance the model, queue the expected outputs
  task automatic step(input logic r_i, input logic ld_i, input logic [15:0] d_i,
                      input logic go_i, input logic hold_i, input logic e_i);
    exp_t x;
    logic zp_e;
    zp_e = 1'b0;
    r = r_i; ld = ld_i; d = d_i; go = go_i; hold = hold_i; e = e_i;
    if (r_i) begin
      secs = 0; mode = 0;
    end else if (ld_i) begin
      secs = load_secs(d_i); mode = 0;
    end else begin
      case (mode)
        0: if (go_i) begin
             if (secs == 0) begin mode = 3; zp_e = 1'b1; end
             else mode = 1;
           end
        1: if (hold_i) mode = 2;
           else if (e_i) begin
             secs = secs - 1;
             if (secs == 0) begin mode = 3; zp_e = 1'b1; end
           end
        2: if (go_i) mode = 1;
        default: ;
      endcase
    end
    x.t    = to_bcd(secs);
    x.run  = (mode == 1);
    x.done = (mode == 3);
    x.zp   = zp_e;
    x.tag  = cur_tag;
    sb.push_back(x);
    @(posedge c);
    @(negedge c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic ldv(input logic [15:0] v);
    step(1'b0, 1'b1, v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic gop();
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: after every edge compare the DUT outputs with the oldest expectation
  always @(posedge c) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_tests++;
      if ({t, run, done, zp} !== {x.t, x.run, x.done, x.zp}) begin
        n_fail++;
        $display("FAIL %s @%0t: got t=%h run=%b done=%b zp=%b, want t=%h run=%b done=%b zp=%b",
                 x.tag, $time, t, run, done, zp, x.t, x.run, x.done, x.zp);
      end
    end
  end

  initial begin
    cur_tag = "reset";
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle(1);

    cur_tag = "count3";
    ldv(16'h0003); gop(); idle(1);
    tick(); idle(2); tick(); tick(); idle(2);

    cur_tag = "t1000";
    ldv(16'h1000); gop(); tick();
    for (int i = 0; i < 599; i++) tick();
    idle(2); tick();

    cur_tag = "clamp";
    ldv(16'h0070); ldv(16'hCC9C); idle(1);

    cur_tag = "hold";
    ldv(16'h0130); gop();
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    gop(); tick();

    cur_tag = "zero_go";
    ldv(16'h0000); gop(); idle(1);
    tick(); tick(); gop(); tick();

    cur_tag = "reset_mid";
    ldv(16'h0412); gop(); tick();
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); idle(1);

    cur_tag = "ld_with_e";
    ldv(16'h0200); gop();
    step(1'b0, 1'b1, 16'h0500, 1'b0, 1'b0, 1'b1); tick();

    cur_tag = "go_with_e";
    ldv(16'h0010);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); tick();

    cur_tag = "random";
    for (int i = 0; i < 4000; i++) begin
      logic        rr, ll, gg, hh, ee;
      logic [15:0] dd;
      rr = ($urandom_range(0, 199) == 0);
      ll = ($urandom_range(0, 59) == 0);
      dd = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                       : {12'h000, 4'($urandom_range(0, 4))};
      gg = ($urandom_range(0, 7) == 0);
      hh = ($urandom_range(0, 11) == 0);
      ee = 1'($urandom_range(0, 1));
      step(rr, ll, dd, gg, hh, ee);
    end

    @(posedge c);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
